// File: rtl/cam_frame_capture_ctrl.sv
// Frame-capture sequencer: OV5642 YUV422 stream -> luma pixels for the BMP writer.
// Optional macro CAP_LINE_CHECK_EN: a short line aborts the frame with cap_err.
module cam_frame_capture_ctrl #(
  parameter int WIDTH    = 640,
  parameter int HEIGHT   = 480,
  parameter int BYTE_SEL = 0
) (
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic       cap_start,
  input  logic       cam_vsync,
  input  logic       cam_href,
  input  logic       cam_pvalid,
  input  logic [7:0] cam_data,
  output logic       pix_we,
  output logic [7:0] pix_data,
  output logic       busy,
  output logic       cap_done,
  output logic       cap_err,
  output logic [8:0] line_cnt
);

  localparam int NPIX = WIDTH * HEIGHT;
  localparam int CW   = $clog2(WIDTH + 1);
  localparam int TW0  = $clog2(NPIX + 1);
  localparam int TW   = (TW0 < 19) ? 19 : TW0;

  localparam logic [CW-1:0] COL_MAX  = CW'(WIDTH);
  localparam logic [TW-1:0] TOT_MAX  = TW'(NPIX);
  localparam logic [TW-1:0] TOT_LAST = TW'(NPIX - 1);
  localparam logic          SEL      = (BYTE_SEL != 0);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]    state;
  logic          vsync_q;
  logic          href_q;
  logic          phase;
  logic [CW-1:0] col;
  logic [TW-1:0] total;

  logic in_cap;
  logic start_ok;
  logic vs_rise;
  logic vs_fall;
  logic href_rise;
  logic href_fall;
  logic phase_cur;
  logic take;
  logic emit;
  logic frame_full;
  logic last_pix;
  logic abort;
  logic short_line;

  assign in_cap     = (state == S_CAPTURE);
  assign start_ok   = (state == S_IDLE) & cap_start;
  assign vs_rise    = cam_vsync & ~vsync_q;
  assign vs_fall    = ~cam_vsync & vsync_q;
  assign href_rise  = cam_href & ~href_q;
  assign href_fall  = ~cam_href & href_q;

  // The byte on the href rising cycle is always phase 0.
  assign phase_cur  = href_rise ? 1'b0 : phase;
  assign take       = in_cap & cam_pvalid & cam_href & (phase_cur == SEL);
  assign frame_full = (total == TOT_MAX);
  assign emit       = take & (col < COL_MAX) & ~frame_full;
  assign last_pix   = emit & (total == TOT_LAST);

  // A vsync rise racing the final pixel is not an error.
  assign abort      = in_cap & vs_rise & ~last_pix & ~frame_full;

`ifdef CAP_LINE_CHECK_EN
  assign short_line = in_cap & href_fall & (col != '0) & (col < COL_MAX);
`else
  assign short_line = 1'b0;
`endif

  assign busy     = (state == S_ARMED) | (state == S_CAPTURE);
  assign cap_done = (state == S_DONE);

  // Registered copies of the camera sync lines for edge detection.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
    end else begin
      vsync_q <= cam_vsync;
      href_q  <= cam_href;
    end
  end

  // Byte-pair phase: cleared by href rise, toggled per in-line byte.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      phase <= 1'b0;
    end else if (cam_pvalid & cam_href) begin
      phase <= ~phase_cur;
    end else begin
      phase <= phase_cur;
    end
  end

  // Frame sequencing; DONE is entered the cycle after the last pix_we.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state <= S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (cap_start) state <= S_ARMED;
        end
        S_ARMED: begin
          if (vs_fall) state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          if (frame_full) begin
            state <= S_DONE;
          end else if (abort | short_line) begin
            state <= S_IDLE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Sticky error, cleared only by an accepted start.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      cap_err <= 1'b0;
    end else if (start_ok) begin
      cap_err <= 1'b0;
    end else if (in_cap & ~frame_full & (abort | short_line)) begin
      cap_err <= 1'b1;
    end
  end

  // Column, frame total and line counters.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      col      <= '0;
      total    <= '0;
      line_cnt <= '0;
    end else if (start_ok) begin
      col      <= '0;
      total    <= '0;
      line_cnt <= '0;
    end else if (in_cap) begin
      if (href_fall) begin
        col <= '0;
        if (col != '0) line_cnt <= line_cnt + 9'd1;
      end else if (emit) begin
        col   <= col + CW'(1);
        total <= total + TW'(1);
      end
    end
  end

  // Registered pixel strobe; data holds between strobes.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      pix_we   <= 1'b0;
      pix_data <= 8'h00;
    end else begin
      pix_we <= emit;
      if (emit) pix_data <= cam_data;
    end
  end

endmodule
